// File: rtl/sig_mem_pkg.sv
// Shared signal-RAM map for the trace writer and the VGA display stage:
// trace/stat word addresses, stat word offsets, channel and FSM encodings,
// and the divide-guard applied to published min/max pairs.
package sig_mem_pkg;

  localparam int unsigned DATA_W    = 12;
  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WPTR_W    = 9;
  localparam int unsigned DECIM_W   = 8;
  localparam int unsigned TRACE_LEN = 320;

  localparam logic [ADDR_W-1:0] ECG_BASE  = 12'h559;
  localparam logic [ADDR_W-1:0] EMG_BASE  = 12'h6AD;
  localparam logic [ADDR_W-1:0] STAT_BASE = 12'd1705;

  // Stat word offsets from STAT_BASE
  localparam logic [1:0] MIN_ECG = 2'd0;
  localparam logic [1:0] MIN_EMG = 2'd1;
  localparam logic [1:0] MAX_ECG = 2'd2;
  localparam logic [1:0] MAX_EMG = 2'd3;

  typedef enum logic {
    CH_ECG = 1'b0,
    CH_EMG = 1'b1
  } ch_e;

  typedef enum logic [2:0] {
    IDLE,
    WR_SAMPLE,
    COMMIT0,
    COMMIT1,
    COMMIT2,
    COMMIT3
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] min_v;
    logic [DATA_W-1:0] max_v;
  } stat_pair_t;

  // The display divides by (max - min); guarantee max > min.
  function automatic stat_pair_t div_guard(stat_pair_t p);
    stat_pair_t r;
    r = p;
    if (p.max_v <= p.min_v) begin
      if (p.min_v == 12'hFFF) begin
        r.min_v = 12'hFFE;
        r.max_v = 12'hFFF;
      end else begin
        r.max_v = p.min_v + 12'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sig_channel_stats.sv
// Per-channel min/max tracker.
// Ports: clock/reset; upd_i folds data_i into the running min/max;
// commit_i latches the published pair and restarts tracking;
// pub_min_c/pub_max_c are the (guarded) values the next commit publishes.
module sig_channel_stats
  import sig_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        upd_i,
  input  logic        commit_i,
  input  logic [11:0] data_i,
  output logic [11:0] pub_min_c,
  output logic [11:0] pub_max_c
);

  logic [DATA_W-1:0] run_min_q, run_min_d;
  logic [DATA_W-1:0] run_max_q, run_max_d;
  logic              seen_q, seen_d;
  stat_pair_t        com_q, com_d;
  stat_pair_t        run_c, pub_c;

  // A channel with nothing seen republishes its last committed pair.
  always_comb begin
    run_c.min_v = run_min_q;
    run_c.max_v = run_max_q;
    pub_c       = seen_q ? div_guard(run_c) : com_q;
    run_min_d   = run_min_q;
    run_max_d   = run_max_q;
    seen_d      = seen_q;
    com_d       = com_q;
    if (commit_i) begin
      com_d     = pub_c;
      run_min_d = 12'hFFF;
      run_max_d = 12'h000;
      seen_d    = 1'b0;
    end else if (upd_i) begin
      if (data_i < run_min_q) run_min_d = data_i;
      if (data_i > run_max_q) run_max_d = data_i;
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      run_min_q   <= 12'hFFF;
      run_max_q   <= 12'h000;
      seen_q      <= 1'b0;
      com_q.min_v <= 12'h000;
      com_q.max_v <= 12'hFFF;
    end else begin
      run_min_q <= run_min_d;
      run_max_q <= run_max_d;
      seen_q    <= seen_d;
      com_q     <= com_d;
    end
  end

  assign pub_min_c = pub_c.min_v;
  assign pub_max_c = pub_c.max_v;

endmodule

// File: rtl/sig_trace_writer.sv
// Decimates ECG/EMG samples into two circular traces in the signal RAM and
// publishes per-channel min/max stat words once per frame.
// Ports: clock/reset; sample_valid/sample_ready/sample_ch/sample_data input
// stream; frame_tick end-of-frame pulse; mem_wEn/mem_addr/mem_data RAM write
// port; busy high whenever the FSM is not IDLE.
module sig_trace_writer #(
  parameter int unsigned DECIM     = 1,
  parameter int unsigned TRACE_LEN = sig_mem_pkg::TRACE_LEN,
  parameter logic [11:0] ECG_BASE  = sig_mem_pkg::ECG_BASE,
  parameter logic [11:0] EMG_BASE  = sig_mem_pkg::EMG_BASE,
  parameter logic [11:0] STAT_BASE = sig_mem_pkg::STAT_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sample_valid,
  output logic        sample_ready,
  input  logic        sample_ch,
  input  logic [11:0] sample_data,
  input  logic        frame_tick,
  output logic        mem_wEn,
  output logic [11:0] mem_addr,
  output logic [31:0] mem_data,
  output logic        busy
);
  import sig_mem_pkg::*;

  localparam logic [DECIM_W-1:0] DECIM_LAST = DECIM_W'(DECIM - 1);
  localparam logic [WPTR_W-1:0]  WPTR_LAST  = WPTR_W'(TRACE_LEN - 1);

  state_e                   state_q, state_d;
  logic                     pending_q, pending_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     wen_q, wen_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [WORD_W-1:0]        data_q, data_d;
  logic [1:0][DECIM_W-1:0]  cnt_q, cnt_d;
  logic [1:0][WPTR_W-1:0]   wptr_q, wptr_d;

  logic                     accept_c, keep_c, commit_c;
  logic                     stat_wr_c;
  logic [1:0]               stat_sel_c;
  logic [ADDR_W-1:0]        base_c;
  logic [3:0][DATA_W-1:0]   stat_word_c;
  logic [DATA_W-1:0]        ecg_min_c, ecg_max_c, emg_min_c, emg_max_c;

  assign accept_c = sample_valid && ready_q;
  assign keep_c   = accept_c && (cnt_q[sample_ch] == '0);
  assign base_c   = (ch_e'(sample_ch) == CH_EMG) ? EMG_BASE : ECG_BASE;

  assign stat_word_c[MIN_ECG] = ecg_min_c;
  assign stat_word_c[MIN_EMG] = emg_min_c;
  assign stat_word_c[MAX_ECG] = ecg_max_c;
  assign stat_word_c[MAX_EMG] = emg_max_c;

  sig_channel_stats u_ecg_stats (
    .clock     (clock),
    .reset     (reset),
    .upd_i     (keep_c && (ch_e'(sample_ch) == CH_ECG)),
    .commit_i  (commit_c),
    .data_i    (sample_data),
    .pub_min_c (ecg_min_c),
    .pub_max_c (ecg_max_c)
  );

  sig_channel_stats u_emg_stats (
    .clock     (clock),
    .reset     (reset),
    .upd_i     (keep_c && (ch_e'(sample_ch) == CH_EMG)),
    .commit_i  (commit_c),
    .data_i    (sample_data),
    .pub_min_c (emg_min_c),
    .pub_max_c (emg_max_c)
  );

  // Next state; the write registers are loaded for the state being entered.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | frame_tick;
    cnt_d      = cnt_q;
    wptr_d     = wptr_q;
    wen_d      = 1'b0;
    addr_d     = addr_q;
    data_d     = data_q;
    commit_c   = 1'b0;
    stat_wr_c  = 1'b0;
    stat_sel_c = 2'd0;

    if (accept_c) begin
      cnt_d[sample_ch] = (cnt_q[sample_ch] == DECIM_LAST) ? '0
                                                          : cnt_q[sample_ch] + DECIM_W'(1);
    end
    if (keep_c) begin
      wptr_d[sample_ch] = (wptr_q[sample_ch] == WPTR_LAST) ? '0
                                                           : wptr_q[sample_ch] + WPTR_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (keep_c) begin
          state_d = WR_SAMPLE;
          wen_d   = 1'b1;
          addr_d  = base_c + ADDR_W'(wptr_q[sample_ch]);
          data_d  = WORD_W'(sample_data);
        end else if (pending_q) begin
          state_d    = COMMIT0;
          stat_wr_c  = 1'b1;
          stat_sel_c = 2'd0;
        end
      end
      WR_SAMPLE: begin
        if (pending_q) begin
          state_d    = COMMIT0;
          stat_wr_c  = 1'b1;
          stat_sel_c = 2'd0;
        end else begin
          state_d = IDLE;
        end
      end
      COMMIT0: begin
        state_d    = COMMIT1;
        stat_wr_c  = 1'b1;
        stat_sel_c = 2'd1;
      end
      COMMIT1: begin
        state_d    = COMMIT2;
        stat_wr_c  = 1'b1;
        stat_sel_c = 2'd2;
      end
      COMMIT2: begin
        state_d    = COMMIT3;
        stat_wr_c  = 1'b1;
        stat_sel_c = 2'd3;
      end
      COMMIT3: begin
        // Clearing wins over a tick landing in the last commit cycle.
        state_d   = IDLE;
        commit_c  = 1'b1;
        pending_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    if (stat_wr_c) begin
      wen_d  = 1'b1;
      addr_d = STAT_BASE + ADDR_W'(stat_sel_c);
      data_d = WORD_W'(stat_word_c[stat_sel_c]);
    end
  end

  // Ready is dropped one cycle ahead of a commit so no sample is lost.
  assign ready_d = (state_d == IDLE) && !pending_d;
  assign busy_d  = (state_d != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      wen_q     <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      wen_q     <= wen_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
    end
  end

  assign sample_ready = ready_q;
  assign busy         = busy_q;
  assign mem_wEn      = wen_q;
  assign mem_addr     = addr_q;
  assign mem_data     = data_q;

endmodule

// File: doc/sig_trace_writer.md
# sig_trace_writer

Upstream producer for the VGA signal display: accepts a stream of 12-bit ECG/EMG samples, decimates them, writes them into the shared signal RAM as two 320-entry circular traces, and once per video frame publishes the per-channel min/max words that the display stage reads for vertical scaling. It owns the write port of the signal RAM; the display stage only reads.

## Interface
Parameters:
- DECIM, 1: keep 1 of every DECIM accepted samples per channel (1..255)
- TRACE_LEN, 320: entries per channel trace
- ECG_BASE, 12'h559: first word of ECG trace
- EMG_BASE, 12'h6AD: first word of EMG trace
- STAT_BASE, 12'd1705: first of four stat words

Ports (one clock; reset is asynchronous and active-high):
- clock  in  1  system clock (100 MHz)
- reset  in  1  async active-high reset
- sample_valid  in  1  sample present
- sample_ready  out  1  block can accept a sample this cycle
- sample_ch  in  1  0 = ECG, 1 = EMG
- sample_data  in  12  unsigned sample
- frame_tick  in  1  one-cycle pulse at end of visible frame
- mem_wEn  out  1  signal-RAM write strobe
- mem_addr  out  12  signal-RAM write address
- mem_data  out  32  signal-RAM write data
- busy  out  1  high while state != IDLE

## Operation
- Accept = sample_valid && sample_ready. Per-channel decimation counter 0..DECIM-1; sample kept only when counter == 0, counter then increments and wraps to 0 after DECIM-1.
- Kept sample: write {20'b0, sample_data} to BASE(ch) + wptr(ch); wptr(ch) increments, wraps TRACE_LEN-1 -> 0.
- Kept sample also updates channel running min/max (unsigned compare). A channel with no kept samples since last commit keeps its previously committed values.
- frame_tick sets commit_pending (sticky until serviced; extra ticks while pending are absorbed).
- FSM: IDLE -> WR_SAMPLE on kept sample (if pending too, sample first); IDLE -> COMMIT0 when commit_pending and no kept sample this cycle; COMMIT0..COMMIT3 write STAT_BASE+0..3 = min_ecg, min_emg, max_ecg, max_emg; COMMIT3 -> IDLE, clears commit_pending and resets running trackers (min=12'hFFF, max=0, "seen"=0).
- Divide-guard: if committed max <= min, max word written as min+1 (saturating at 4095, min forced to 4094 in that case).
- sample_ready = 1 only in IDLE and not entering COMMIT; deasserted during WR_SAMPLE and COMMIT0..3.

## Timing
- Reset values: sample_ready=1, mem_wEn=0, mem_addr=0, mem_data=0, busy=0; wptrs=0, decim counters=0, committed min=0/max=4095 both channels, commit_pending=0.
- Sample write latency: accept in cycle N -> mem_wEn=1 with address/data registered in cycle N+1, exactly one cycle wide.
- Commit: 4 consecutive mem_wEn cycles, addresses strictly ascending; sample_ready low for all 4 plus the following cycle back in IDLE is high again.
- frame_tick coincident with accept: sample write at N+1, COMMIT0 at N+2.
- Discarded (decimated) samples: accepted, no write, ready stays high.
- Reset mid-commit: outputs to reset values immediately; partial stat writes are not completed or retried.
- Max throughput: one kept sample every 2 cycles.

## Structure
- Package sig_mem_pkg: ECG_BASE, EMG_BASE, STAT_BASE, TRACE_LEN, stat offsets (MIN_ECG=0, MIN_EMG=1, MAX_ECG=2, MAX_EMG=3), channel enum, FSM state enum; shared with the display stage.
- Sub-module sig_channel_stats: one per channel; running min/max/seen tracker with clear, plus committed registers and divide-guard.

## Test plan
- Reset, no traffic, frame_tick -> writes 1705..1708 = 0, 0, 4095, 4095.
- DECIM=1, ECG samples 100, 300, 200 -> writes 0x559=100, 0x55A=300, 0x55B=200; frame_tick -> 1705=100, 1707=300, EMG words unchanged previous values.
- 321 EMG samples value k -> last sample written to 0x6AD (wrap), wptr(EMG)=1.
- Constant ECG 500 then frame_tick -> min_ecg=500, max_ecg=501; constant 4095 -> 4094/4095.
- DECIM=4, 8 ECG samples 1..8 -> only 1 and 5 written, at 0x559 and 0x55A.
- frame_tick same cycle as accepted sample, then assert reset during COMMIT1 -> sample write, COMMIT0 write, then all outputs zero, sample_ready=1, no further writes.
